// File: rtl/fsmc_mux_bridge.sv
// fsmc_mux_bridge: STM32 FSMC address/data-multiplexed bus slave.
// Decodes the latched address to channels and converts MCU cycles to strobes.
module fsmc_mux_bridge #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int CS_BITS     = 3,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  inout  wire  [ADDR_W-1:0]         AD,
  input  logic                      NADV,
  input  logic                      NWE,
  input  logic                      NOE,
  output logic [NUM_CH-1:0]         ch_sel,
  output logic [ADDR_W-CS_BITS-1:0] ch_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_stb,
  output logic                      rd_req,
  input  logic [DATA_W-1:0]         rd_data,
  input  logic                      rd_valid,
  output logic [2:0]                err
);

  localparam int CA_W  = ADDR_W - CS_BITS;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, DECODE, ACTIVE, RD_WAIT, RD_DRIVE
  } state_e;

  state_e                          state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0]     sync_q;
  logic [2:0]                      hist_q;
  logic [2:0]                      s;
  logic                            adv_rise, we_rise;
  logic                            oe_fall, oe_rise;
  logic [CS_BITS-1:0]              idx_q, idx_d;
  logic [NUM_CH-1:0]               ch_sel_q, ch_sel_d;
  logic [CA_W-1:0]                 ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0]               wr_data_q, wr_data_d;
  logic [DATA_W-1:0]               rd_data_q, rd_data_d;
  logic [TMO_W-1:0]                tmo_q, tmo_d;
  logic                            wr_stb_q, wr_stb_d;
  logic                            rd_req_q, rd_req_d;
  logic [2:0]                      err_q, err_d;

  // Synchronize {NADV,NWE,NOE}; idle-high so reset sees no edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {NADV, NWE, NOE}};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign adv_rise = s[2] & ~hist_q[2];
  assign we_rise  = s[1] & ~hist_q[1];
  assign oe_rise  = s[0] & ~hist_q[0];
  assign oe_fall  = ~s[0] & hist_q[0];

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ch_sel_q  <= '0;
      ch_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      tmo_q     <= '0;
      wr_stb_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ch_sel_q  <= ch_sel_d;
      ch_addr_q <= ch_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      tmo_q     <= tmo_d;
      wr_stb_q  <= wr_stb_d;
      rd_req_q  <= rd_req_d;
      err_q     <= err_d;
    end
  end

  // Next state; a new address phase pre-empts everything else.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ch_sel_d  = ch_sel_q;
    ch_addr_d = ch_addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    tmo_d     = tmo_q;
    wr_stb_d  = 1'b0;
    rd_req_d  = 1'b0;
    err_d     = '0;
    if (adv_rise) begin
      ch_addr_d = AD[CA_W-1:0];
      idx_d     = AD[ADDR_W-1 -: CS_BITS];
      ch_sel_d  = '0;
      state_d   = DECODE;
    end else begin
      unique case (state_q)
        IDLE: ;
        DECODE: begin
          if (int'(idx_q) < NUM_CH) begin
            ch_sel_d = NUM_CH'(1) << idx_q;
            tmo_d    = '0;
            state_d  = ACTIVE;
          end else begin
            err_d    = 3'b001;
            ch_sel_d = '0;
            state_d  = IDLE;
          end
        end
        ACTIVE: begin
          if (we_rise) begin
            wr_data_d = AD[DATA_W-1:0];
            wr_stb_d  = 1'b1;
            ch_sel_d  = '0;
            state_d   = IDLE;
          end else if (oe_fall) begin
            rd_req_d = 1'b1;
            state_d  = RD_WAIT;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
            err_d    = 3'b010;
            ch_sel_d = '0;
            state_d  = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        RD_WAIT: begin
          if (oe_rise) begin
            err_d    = 3'b100;
            ch_sel_d = '0;
            state_d  = IDLE;
          end else if (rd_valid) begin
            rd_data_d = rd_data;
            state_d   = RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (oe_rise) begin
            ch_sel_d = '0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign AD      = (state_q == RD_DRIVE) ? ADDR_W'(rd_data_q) : 'z;
  assign ch_sel  = ch_sel_q;
  assign ch_addr = ch_addr_q;
  assign wr_data = wr_data_q;
  assign wr_stb  = wr_stb_q;
  assign rd_req  = rd_req_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fsmc_mux_bridge.sv
// tb_fsmc_mux_bridge: directed bench for fsmc_mux_bridge.
// Two instances (2-stage/16-bit, 3-stage/8-bit) share the MCU stimulus.
module tb_fsmc_mux_bridge;

  localparam logic [17:0] FLOAT = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        NADV = 1'b1, NWE = 1'b1, NOE = 1'b1;
  logic        mcu_oe = 1'b0;
  logic [17:0] mcu_ad = '0;
  wire  [17:0] ad0, ad1;

  logic [3:0]  ch_sel0, ch_sel1;
  logic [14:0] ch_addr0, ch_addr1;
  logic [15:0] wr_data0;
  logic [7:0]  wr_data1;
  logic        wr_stb0, wr_stb1, rd_req0, rd_req1;
  logic [15:0] rd_data0 = '0;
  logic [7:0]  rd_data1 = '0;
  logic        rd_valid0 = 1'b0, rd_valid1 = 1'b0;
  logic [2:0]  err0, err1;

  logic [15:0] rd_pat = 16'h1234;
  bit          rd_mode = 1'b0;
  int          dly[2];
  int          wr_n[2], rq_n[2], both_n;
  int          e_n[2][3];
  logic [15:0] wdat[2];
  logic [3:0]  ch_or[2];
  bit          drv_seen[2];
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  assign ad0 = mcu_oe ? mcu_ad : 'z;
  assign ad1 = mcu_oe ? mcu_ad : 'z;

  for (genvar g = 0; g < 18; g++) begin : g_pu
    pullup (ad0[g]);
    pullup (ad1[g]);
  end

  fsmc_mux_bridge #(
    .ADDR_W(18), .DATA_W(16), .CS_BITS(3), .NUM_CH(4),
    .SYNC_STAGES(2), .TIMEOUT_CYC(255)
  ) u_dut0 (
    .clk(clk), .reset(reset), .AD(ad0),
    .NADV(NADV), .NWE(NWE), .NOE(NOE),
    .ch_sel(ch_sel0), .ch_addr(ch_addr0),
    .wr_data(wr_data0), .wr_stb(wr_stb0),
    .rd_req(rd_req0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .err(err0)
  );

  fsmc_mux_bridge #(
    .ADDR_W(18), .DATA_W(8), .CS_BITS(3), .NUM_CH(4),
    .SYNC_STAGES(3), .TIMEOUT_CYC(255)
  ) u_dut1 (
    .clk(clk), .reset(reset), .AD(ad1),
    .NADV(NADV), .NWE(NWE), .NOE(NOE),
    .ch_sel(ch_sel1), .ch_addr(ch_addr1),
    .wr_data(wr_data1), .wr_stb(wr_stb1),
    .rd_req(rd_req1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .err(err1)
  );

  // Peripheral model (data 2 cycles after rd_req) and event monitor.
  always @(negedge clk) begin
    rd_valid0 = 1'b0;
    rd_valid1 = 1'b0;
    if (dly[0] > 0) begin
      dly[0]--;
      if (dly[0] == 0) begin
        rd_valid0 = 1'b1;
        rd_data0  = rd_pat;
      end
    end
    if (dly[1] > 0) begin
      dly[1]--;
      if (dly[1] == 0) begin
        rd_valid1 = 1'b1;
        rd_data1  = rd_pat[7:0];
      end
    end
    if (rd_req0 && !rd_mode) dly[0] = 2;
    if (rd_req1 && !rd_mode) dly[1] = 2;
    if (wr_stb0) begin wr_n[0]++; wdat[0] = wr_data0; end
    if (wr_stb1) begin wr_n[1]++; wdat[1] = {8'h00, wr_data1}; end
    if (rd_req0) rq_n[0]++;
    if (rd_req1) rq_n[1]++;
    if ((wr_stb0 && rd_req0) || (wr_stb1 && rd_req1)) both_n++;
    for (int b = 0; b < 3; b++) begin
      if (err0[b]) e_n[0][b]++;
      if (err1[b]) e_n[1][b]++;
    end
    ch_or[0] |= ch_sel0;
    ch_or[1] |= ch_sel1;
    if (!mcu_oe && ad0 !== FLOAT) drv_seen[0] = 1'b1;
    if (!mcu_oe && ad1 !== FLOAT) drv_seen[1] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      wr_n[i] = 0; rq_n[i] = 0; ch_or[i] = '0;
      drv_seen[i] = 1'b0; wdat[i] = '0;
      for (int b = 0; b < 3; b++) e_n[i][b] = 0;
    end
  endtask

  task automatic adr(input logic [17:0] a);
    mcu_oe = 1'b1; mcu_ad = a; NADV = 1'b0;
    tick(6);
    NADV = 1'b1;
    tick(6);
  endtask

  task automatic wdata(input logic [15:0] d);
    mcu_ad = {2'b00, d}; NWE = 1'b0;
    tick(6);
    NWE = 1'b1;
    tick(6);
    mcu_oe = 1'b0;
    tick(2);
  endtask

  initial begin
    both_n = 0; dly[0] = 0; dly[1] = 0;
    clr();
    tick(3);
    chk("rst_ch_sel0", ch_sel0, 4'h0);
    chk("rst_ch_addr0", ch_addr0, 15'h0);
    chk("rst_wr_data0", wr_data0, 16'h0);
    chk("rst_strobes", {wr_stb0, rd_req0, wr_stb1, rd_req1}, 4'h0);
    chk("rst_err", {err0, err1}, 6'h0);
    chk("rst_ad_float", {ad0 == FLOAT, ad1 == FLOAT}, 2'b11);
    reset = 1'b1;
    tick(3);

    // write ch1
    clr();
    adr(18'h08005);
    chk("wr_ch_sel0", ch_sel0, 4'b0010);
    chk("wr_ch_sel1", ch_sel1, 4'b0010);
    chk("wr_ch_addr0", ch_addr0, 15'h0005);
    chk("wr_ch_addr1", ch_addr1, 15'h0005);
    wdata(16'hA55A);
    chk("wr_stb_n0", wr_n[0], 1);
    chk("wr_stb_n1", wr_n[1], 1);
    chk("wr_data0", wdat[0], 16'hA55A);
    chk("wr_data1", wdat[1], 16'h005A);
    chk("wr_ch_sel_after", {ch_sel0, ch_sel1}, 8'h00);

    // read ch3
    clr();
    rd_pat = 16'h1234;
    adr(18'h18000);
    chk("rd_ch_sel0", ch_sel0, 4'b1000);
    mcu_oe = 1'b0; NOE = 1'b0;
    tick(10);
    chk("rd_req_n", {rq_n[0][7:0], rq_n[1][7:0]}, 16'h0101);
    chk("rd_ad0", ad0, 18'h01234);
    chk("rd_ad1", ad1, 18'h00034);
    NOE = 1'b1;
    tick(2);
    chk("rd_ad0_hold", ad0, 18'h01234);
    tick(1);
    chk("rd_ad0_rel", ad0, FLOAT);
    chk("rd_ad1_hold", ad1, 18'h00034);
    tick(1);
    chk("rd_ad1_rel", ad1, FLOAT);
    tick(4);
    chk("rd_ch_sel_after", {ch_sel0, ch_sel1}, 8'h00);
    chk("rd_no_err", e_n[0][0] + e_n[0][1] + e_n[0][2], 0);

    // decode error, idx 5
    clr();
    adr(18'h28000);
    wdata(16'hFFFF);
    chk("dec_err0", {e_n[0][2][3:0], e_n[0][1][3:0], e_n[0][0][3:0]}, 12'h001);
    chk("dec_err1", {e_n[1][2][3:0], e_n[1][1][3:0], e_n[1][0][3:0]}, 12'h001);
    chk("dec_no_wr", wr_n[0] + wr_n[1], 0);
    chk("dec_no_sel", {ch_or[0], ch_or[1]}, 8'h00);
    chk("dec_no_drv", {drv_seen[0], drv_seen[1]}, 2'b00);

    // late read: rd_valid withheld
    clr();
    rd_mode = 1'b1;
    adr(18'h00003);
    mcu_oe = 1'b0; NOE = 1'b0;
    tick(8);
    NOE = 1'b1;
    tick(8);
    rd_mode = 1'b0;
    chk("late_err0", {e_n[0][2][3:0], e_n[0][1][3:0], e_n[0][0][3:0]}, 12'h100);
    chk("late_err1", {e_n[1][2][3:0], e_n[1][1][3:0], e_n[1][0][3:0]}, 12'h100);
    chk("late_no_drv", {drv_seen[0], drv_seen[1]}, 2'b00);
    chk("late_sel_after", {ch_sel0, ch_sel1}, 8'h00);

    // timeout, exact cycle
    clr();
    mcu_oe = 1'b1; mcu_ad = 18'h08000; NADV = 1'b0;
    tick(6);
    NADV = 1'b1;
    tick(259);
    mcu_oe = 1'b0;
    chk("tmo_early0", e_n[0][1], 0);
    tick(1);
    chk("tmo_err0", err0, 3'b010);
    chk("tmo_err1_pre", err1, 3'b000);
    tick(1);
    chk("tmo_err1", err1, 3'b010);
    chk("tmo_err0_once", err0, 3'b000);
    tick(3);
    chk("tmo_sel_after", {ch_sel0, ch_sel1}, 8'h00);

    // back-to-back write then read
    clr();
    rd_pat = 16'h5678;
    adr(18'h10010);
    wdata(16'hBEEF);
    adr(18'h10020);
    chk("b2b_ch_sel", ch_sel0, 4'b0100);
    mcu_oe = 1'b0; NOE = 1'b0;
    tick(10);
    chk("b2b_ad0", ad0, 18'h05678);
    chk("b2b_ad1", ad1, 18'h00078);
    NOE = 1'b1;
    tick(8);
    chk("b2b_wr0", wdat[0], 16'hBEEF);
    chk("b2b_wr1", wdat[1], 16'h00EF);
    chk("b2b_cnt", {wr_n[0][3:0], rq_n[0][3:0], wr_n[1][3:0], rq_n[1][3:0]}, 16'h1111);
    chk("b2b_rel", {ad0 == FLOAT, ad1 == FLOAT}, 2'b11);

    // reset during RD_DRIVE
    rd_pat = 16'hC3C3;
    adr(18'h18001);
    mcu_oe = 1'b0; NOE = 1'b0;
    tick(10);
    chk("rstrd_drv", ad0, 18'h0C3C3);
    reset = 1'b0;
    #1;
    chk("rstrd_ad", {ad0 == FLOAT, ad1 == FLOAT}, 2'b11);
    chk("rstrd_sel", {ch_sel0, ch_sel1}, 8'h00);
    chk("rstrd_addr", {ch_addr0, ch_addr1}, 30'h0);
    chk("rstrd_data", {wr_data0, wr_data1}, 24'h0);
    chk("rstrd_out", {wr_stb0, rd_req0, err0, wr_stb1, rd_req1, err1}, 10'h0);
    NOE = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(8);
    chk("rstrd_ad_after", {ad0 == FLOAT, ad1 == FLOAT}, 2'b11);

    chk("never_both", both_n, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
